ram_io_loader: RTL and testbench
================================

// Module: ram_io_loader
// PURPOSE
//  Write-side counterpart to the read-only weight/IO RAM wrappers. Accepts a byte
//  stream (valid/ready) from the host link, packs byte pairs little-endian into
//  16-bit words and writes them into the 1024x16 IO RAM port from a base address.
//  Used to load one 28x28 MNIST image (784 words) before inference starts.
// PARAMETERS
//  ADDR_W   10   RAM address width; address arithmetic is modulo 2**ADDR_W
//  DATA_W   16   RAM word width; fixed at 2 bytes per word
//  N_WORDS  784  words per load, 1..2**ADDR_W
// PORTS
//  Clk          in   1       system clock; all logic on rising edge
//  Reset_n      in   1       asynchronous, active-low reset
//  Start        in   1       begin a load; sampled only in IDLE
//  Base_Addr    in   ADDR_W  first RAM address; latched on accepted Start
//  Byte_In      in   8       stream data
//  Byte_Valid   in   1       Byte_In is valid
//  Byte_Ready   out  1       loader can accept a byte this cycle
//  Ram_Address  out  ADDR_W  RAM write address
//  Ram_Data     out  DATA_W  RAM write data, {hi_byte, lo_byte}
//  Ram_Wren     out  1       RAM write enable, one cycle per word
//  Busy         out  1       high from accepted Start until DONE completes
//  Done         out  1       one-cycle pulse after the last word is written
//  Word_Count   out  ADDR_W+1  words written since the last accepted Start
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (Reset_n=0, any time, including mid-load):
//    - State goes to IDLE at once.
//    - All outputs go to 0: Byte_Ready, Ram_Wren, Busy, Done, Ram_Address,
//      Ram_Data, Word_Count.
//    - A partially assembled word is discarded and no write occurs.
//  - Byte transfer: a byte moves only in a cycle with Byte_Valid & Byte_Ready.
//    - Byte_In is held by the source while Byte_Valid=1 and Byte_Ready=0.
//    - Byte_Ready does not depend combinationally on Byte_Valid.
//  - FSM states and transitions:
//    - IDLE: Byte_Ready=0, Busy=0.
//      - On Start=1: latch addr<=Base_Addr, Word_Count<=0, Busy<=1, go to GET_LO.
//    - GET_LO: Byte_Ready=1.
//      - On transfer: lo<=Byte_In, go to GET_HI.
//    - GET_HI: Byte_Ready=1.
//      - On transfer: hi<=Byte_In, go to WRITE.
//    - WRITE: Byte_Ready=0.
//      - Drive Ram_Wren=1 for exactly this cycle, with Ram_Address=addr and
//        Ram_Data={hi,lo}.
//      - Update addr<=addr+1 (wraps 2**ADDR_W-1 -> 0) and Word_Count<=Word_Count+1.
//      - If Word_Count+1==N_WORDS go to DONE, else go to GET_LO.
//    - DONE: Done=1 for one cycle, Busy<=0, go to IDLE.
//  - Latency:
//    - Accepted Start -> Byte_Ready=1 on the next cycle.
//    - Hi byte transfer -> Ram_Wren=1 on the next cycle.
//    - Last write -> Done on the next cycle.
//    - Minimum throughput is 3 cycles per word.
//  - Start is ignored in every state except IDLE. Start in the same cycle as the
//    DONE pulse is ignored; Start on the following cycle is accepted.
//  - Byte_Valid asserted in IDLE, WRITE or DONE is not consumed; the byte is held.
//  - Ram_Address and Ram_Data hold their last values while Ram_Wren=0.
//  - Word_Count holds N_WORDS after Done until the next accepted Start.
// TESTING
//  - Reset values: assert Reset_n=0 mid-cycle -> all outputs 0 asynchronously,
//    before the next Clk edge.
//  - Basic load, N_WORDS=3, Base_Addr=10, bytes 01 02 03 04 05 06 with Valid held
//    high -> writes 0x0201@10, 0x0403@11, 0x0605@12, 3 cycles apart; Done 1 cycle
//    after the last write; Word_Count=3.
//  - Backpressure: Byte_Valid toggled randomly -> exactly N_WORDS writes with
//    correct data; no byte lost or duplicated; Byte_Ready=0 in every WRITE cycle.
//  - Wrap: Base_Addr=1022, N_WORDS=4 -> writes at 1022, 1023, 0, 1.
//  - Start while Busy: pulse Start with Base_Addr=500 mid-load -> ignored;
//    addresses continue from the original base.
//  - Reset mid-load: Reset_n=0 after the lo byte of word 5 -> no write for word 5;
//    after release the FSM is in IDLE; a new Start loads cleanly from the new base.

Source files
------------

// File: rtl/ram_io_loader.sv
// ram_io_loader: packs a host byte stream little-endian into 16-bit words and writes them
// into the IO RAM from a base address, one load of N_WORDS words per accepted Start.
module ram_io_loader #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int N_WORDS = 784
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [7:0]        Byte_In,
  input  logic              Byte_Valid,
  output logic              Byte_Ready,
  output logic [ADDR_W-1:0] Ram_Address,
  output logic [DATA_W-1:0] Ram_Data,
  output logic              Ram_Wren,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W:0]   Word_Count
);
  typedef enum logic [2:0] {IDLE, GET_LO, GET_HI, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(N_WORDS - 1);
  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo;
  logic              xfer;
  logic              last;
  assign xfer = Byte_Valid & Byte_Ready;
  assign last = Word_Count == LAST;
  // Byte_Ready is registered: it is set on entry to GET_LO and cleared on entry to WRITE
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state       <= IDLE;
      addr        <= '0;
      lo          <= '0;
      Byte_Ready  <= 1'b0;
      Ram_Address <= '0;
      Ram_Data    <= '0;
      Ram_Wren    <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Word_Count  <= '0;
    end else
      case (state)
        IDLE: if (Start) begin
          addr       <= Base_Addr;
          Word_Count <= '0;
          Busy       <= 1'b1;
          Byte_Ready <= 1'b1;
          state      <= GET_LO;
        end
        GET_LO: if (xfer) begin
          lo    <= Byte_In;
          state <= GET_HI;
        end
        GET_HI: if (xfer) begin
          Ram_Address <= addr;
          Ram_Data    <= {Byte_In, lo};
          Ram_Wren    <= 1'b1;
          Byte_Ready  <= 1'b0;
          state       <= WRITE;
        end
        WRITE: begin
          Ram_Wren   <= 1'b0;
          addr       <= addr + 1'b1;
          Word_Count <= Word_Count + 1'b1;
          Byte_Ready <= !last;
          Done       <= last;
          state      <= last ? DONE : GET_LO;
        end
        DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_ram_io_loader.sv
// tb_ram_io_loader: random-stream loads checked against an address/data list built from the sent bytes.
module tb_ram_io_loader;
  localparam int NW = 6;
  logic        Clk = 0, Reset_n = 1, Start = 0, Byte_Valid = 0;
  logic [9:0]  Base_Addr = '0;
  logic [7:0]  Byte_In = '0;
  logic        Byte_Ready, Ram_Wren, Busy, Done;
  logic [9:0]  Ram_Address;
  logic [15:0] Ram_Data;
  logic [10:0] Word_Count;
  int errors = 0, checks = 0, cyc = 0, ready_bad = 0, dc = 0;
  logic [25:0] wq[$];
  int          wcyc[$];
  logic [7:0]  src[$];

  ram_io_loader #(.ADDR_W(10), .DATA_W(16), .N_WORDS(NW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Base_Addr(Base_Addr),
    .Byte_In(Byte_In), .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .Ram_Address(Ram_Address), .Ram_Data(Ram_Data), .Ram_Wren(Ram_Wren),
    .Busy(Busy), .Done(Done), .Word_Count(Word_Count)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;
  always @(negedge Clk)
    if (Reset_n && Ram_Wren) begin
      wq.push_back({Ram_Address, Ram_Data});
      wcyc.push_back(cyc);
      if (Byte_Ready) ready_bad++;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic gen();
    src.delete();
    for (int i = 0; i < 2*NW; i++) src.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_start(input logic [9:0] base);
    @(negedge Clk);
    Start = 1;
    Base_Addr = base;
    @(posedge Clk);
    #1 Start = 0;
    Base_Addr = 10'($urandom_range(1023));
  endtask

  task automatic send(input int first, input int last, input int pct);
    int i = first, n = 0;
    while (i < last && n < 500) begin
      @(negedge Clk);
      n++;
      Byte_In = src[i];
      Byte_Valid = $urandom_range(99) < pct;
      if (Byte_Valid && Byte_Ready) i++;
    end
    if (i < last) check("send_timeout", i, last);
    @(negedge Clk);
    Byte_Valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Done && n < 200);
    if (!Done) check("done_timeout", 0, 1);
    dc = cyc;
  endtask

  task automatic verify(input string tag, input logic [9:0] base);
    check({tag, "_nwrites"}, wq.size(), NW);
    for (int k = 0; k < NW && k < wq.size(); k++) begin
      check({tag, "_addr"}, wq[k][25:16], 10'(base + k));
      check({tag, "_data"}, wq[k][15:0], {src[2*k+1], src[2*k]});
    end
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_ctrl"}, {Byte_Ready, Ram_Wren, Busy, Done}, 0);
    check({tag, "_addr"}, Ram_Address, 0);
    check({tag, "_data"}, Ram_Data, 0);
    check({tag, "_wcnt"}, Word_Count, 0);
  endtask

  initial begin
    #13 Reset_n = 0;
    #1 rst_check("reset");
    @(negedge Clk);
    Reset_n = 1;
    // basic load: known bytes, valid held high
    src.delete();
    for (int i = 1; i <= 2*NW; i++) src.push_back(8'(i));
    wq.delete();
    wcyc.delete();
    do_start(10);
    @(negedge Clk);
    check("start_ready", Byte_Ready, 1);
    check("start_busy", Busy, 1);
    check("start_wcnt", Word_Count, 0);
    send(0, 2*NW, 100);
    wait_done();
    verify("basic", 10);
    for (int k = 1; k < wcyc.size(); k++) check("basic_spacing", wcyc[k] - wcyc[k-1], 3);
    if (wcyc.size() > 0) check("done_latency", dc - wcyc[wcyc.size()-1], 1);
    check("done_wcnt", Word_Count, NW);
    check("done_busy", Busy, 1);
    // Start during the DONE pulse is ignored, the following cycle it is accepted
    Start = 1;
    Base_Addr = 700;
    @(negedge Clk);
    check("done_start_ignored", Busy, 0);
    check("done_start_done", Done, 0);
    check("hold_wcnt", Word_Count, NW);
    @(posedge Clk);
    #1 Start = 0;
    @(negedge Clk);
    check("next_start_busy", Busy, 1);
    check("next_start_wcnt", Word_Count, 0);
    // backpressure
    gen();
    wq.delete();
    send(0, 2*NW, 50);
    wait_done();
    verify("bp", 700);
    check("ready_in_write", ready_bad, 0);
    // address wrap
    gen();
    wq.delete();
    do_start(1022);
    send(0, 2*NW, 70);
    wait_done();
    verify("wrap", 1022);
    // Start while busy is ignored
    gen();
    wq.delete();
    do_start(100);
    send(0, 4, 100);
    @(negedge Clk);
    Start = 1;
    Base_Addr = 500;
    @(negedge Clk);
    Start = 0;
    send(4, 2*NW, 100);
    wait_done();
    verify("busy_start", 100);
    // reset after the lo byte of the fifth word
    gen();
    wq.delete();
    do_start(200);
    send(0, 9, 80);
    #2 Reset_n = 0;
    #1 rst_check("midrst");
    check("midrst_nwrites", wq.size(), 4);
    @(negedge Clk);
    Reset_n = 1;
    Byte_Valid = 1;
    repeat (3) @(negedge Clk);
    check("idle_ready", Byte_Ready, 0);
    check("idle_busy", Busy, 0);
    check("idle_nwrites", wq.size(), 4);
    Byte_Valid = 0;
    gen();
    wq.delete();
    do_start(300);
    send(0, 2*NW, 60);
    wait_done();
    verify("reload", 300);
    check("ready_in_write_all", ready_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
